// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
// Imported by the loader interface, packer and top.
package loader_pkg;

    localparam int WORD_SIZE = 32;
    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CNT  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

    localparam logic [2:0] ST_IDLE = 3'(IDLE);
    localparam logic [2:0] ST_CNT  = 3'(CNT);
    localparam logic [2:0] ST_DATA = 3'(DATA);
    localparam logic [2:0] ST_CHK  = 3'(CHK);
    localparam logic [2:0] ST_DONE = 3'(DONE);
    localparam logic [2:0] ST_ERR  = 3'(ERR);

    // A frame may carry 1..MEM_DEPTH words.
    function automatic logic count_ok(input logic [7:0] c);
        return (c != 8'd0) && (c <= 8'(MEM_DEPTH));
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, instruction memory write port out.
// The loader uses the slave side; host link plus memory use master.
interface program_loader_if;
    import loader_pkg::*;

    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 imem_we;
    logic [ADDR_W-1:0]    imem_addr;
    logic [WORD_SIZE-1:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/program_loader_word_packer.sv
// Packs big-endian bytes into instruction words.
// Pulses word_valid for one cycle after the fourth byte of a word.
module word_packer
    import loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift,
    input  logic [7:0]           data,
    output logic [WORD_SIZE-1:0] word,
    output logic                 word_valid,
    output logic                 last
);

    logic [1:0] cnt;

    // High while the next shifted byte completes a word.
    assign last = (cnt == 2'd3);

    // Shift bytes in MSB first and flag each completed word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt        <= 2'd0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= shift && last;
            if (shift) begin
                word <= {word[WORD_SIZE-9:0], data};
                cnt  <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Frame parser that loads instruction memory and gates core reset.
// The core is released only after a frame with a matching checksum.
module program_loader
    import loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    program_loader_if.slave          bus,
    output logic                     cpu_rst,
    output logic                     load_done,
    output logic                     load_err
);

    logic [2:0]           state;
    logic                 ready;
    logic                 accept;
    logic [ADDR_W-1:0]    idx;
    logic [ADDR_W-1:0]    n_last;
    logic [ADDR_W-1:0]    addr;
    logic [7:0]           xsum;
    logic                 pk_clear;
    logic                 pk_shift;
    logic                 pk_last;
    logic                 pk_valid;
    logic [WORD_SIZE-1:0] pk_word;

    assign accept   = bus.in_valid && ready;
    assign pk_shift = accept && (state == ST_DATA);
    assign pk_clear = accept && (state == ST_CNT);

    assign bus.in_ready   = ready;
    assign bus.imem_we    = pk_valid;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = pk_word;

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .shift      (pk_shift),
        .data       (bus.in_data),
        .word       (pk_word),
        .word_valid (pk_valid),
        .last       (pk_last)
    );

    // Frame FSM: owns word index, write address, checksum and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ready     <= 1'b0;
            idx       <= '0;
            n_last    <= '0;
            addr      <= '0;
            xsum      <= 8'd0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (accept) begin
                unique case (state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (bus.in_data == SYNC_BYTE) begin
                            state     <= ST_CNT;
                            cpu_rst   <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                        end
                    end
                    ST_CNT: begin
                        if (count_ok(bus.in_data)) begin
                            n_last <= ADDR_W'(bus.in_data - 8'd1);
                            idx    <= '0;
                            xsum   <= 8'd0;
                            state  <= ST_DATA;
                        end else begin
                            state    <= ST_ERR;
                            load_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        xsum <= xsum ^ bus.in_data;
                        if (pk_last) begin
                            addr <= idx;
                            idx  <= idx + 1'b1;
                            if (idx == n_last) begin
                                state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (bus.in_data == xsum) begin
                            state     <= ST_DONE;
                            cpu_rst   <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ST_ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, hand sequences
// and random frames compared against a frame-level reference model.
module tb_program_loader;
    import loader_pkg::*;

    typedef logic [7:0]  bq_t[$];
    typedef logic [37:0] wq_t[$];

    typedef struct {
        logic [127:0] v;
        int           len;
        int           nw;
        logic [5:0]   la;
        logic [31:0]  ld;
        logic         done;
        logic         err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_rst;
    logic load_done;
    logic load_err;

    int checks = 0;
    int errors = 0;

    wq_t  got;
    vec_t tbl[7];

    program_loader_if bus();

    program_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen between clock edges.
    always @(negedge clk) begin
        if (bus.imem_we) got.push_back({bus.imem_addr, bus.imem_wdata});
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
    endtask

    task automatic send_g(input logic [7:0] b, input int maxgap);
        if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
        send(b);
    endtask

    task automatic send_stream(input bq_t s, input int maxgap);
        foreach (s[i]) send_g(s[i], maxgap);
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Frame-level reference: walk the byte list by the framing rules.
    function automatic void model(input bq_t s, output wq_t w,
                                  output logic done, output logic err,
                                  output logic crst);
        int i;
        int n;
        logic [7:0] x;
        logic [31:0] wd;
        bit cut;
        w = {};
        i = 0;
        done = 1'b0;
        err = 1'b0;
        crst = 1'b1;
        while (i < s.size()) begin
            if (s[i] != SYNC_BYTE) begin
                i++;
                continue;
            end
            i++;
            done = 1'b0;
            err = 1'b0;
            crst = 1'b1;
            if (i >= s.size()) break;
            n = int'(s[i]);
            i++;
            if (n == 0 || n > MEM_DEPTH) begin
                err = 1'b1;
                continue;
            end
            x = 8'd0;
            cut = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (i + 4 > s.size()) begin
                    cut = 1'b1;
                    break;
                end
                wd = {s[i], s[i+1], s[i+2], s[i+3]};
                x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                w.push_back({6'(k), wd});
                i += 4;
            end
            if (cut || i >= s.size()) break;
            if (s[i] == x) begin
                done = 1'b1;
                crst = 1'b0;
            end else begin
                err = 1'b1;
            end
            i++;
        end
    endfunction

    task automatic compare_model(input string nm, input bq_t s);
        wq_t  w;
        logic d;
        logic e;
        logic c;
        model(s, w, d, e, c);
        chk({nm, "_nwr"}, 64'(got.size()), 64'(w.size()));
        for (int k = 0; k < w.size() && k < got.size(); k++) begin
            chk({nm, "_wr"}, 64'(got[k]), 64'(w[k]));
        end
        chk({nm, "_done"}, 64'(load_done), 64'(d));
        chk({nm, "_err"}, 64'(load_err), 64'(e));
        chk({nm, "_cpu_rst"}, 64'(cpu_rst), 64'(c));
    endtask

    initial begin
        bq_t s;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] x;
        logic [31:0] wd;
        int sel;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        tbl[0] = '{128'hA5_01_12345678_08, 7, 1, 6'd0, 32'h12345678,
                   1'b1, 1'b0};
        tbl[1] = '{128'hA5_01_12345678_00, 7, 1, 6'd0, 32'h12345678,
                   1'b0, 1'b1};
        tbl[2] = '{128'hA5_00, 2, 0, 6'd0, 32'h0, 1'b0, 1'b1};
        tbl[3] = '{128'hA5_41_11_22_01, 5, 0, 6'd0, 32'h0, 1'b0, 1'b1};
        tbl[4] = '{128'h00_FF_3C_A5_01_DEADBEEF_22, 10, 1, 6'd0,
                   32'hDEADBEEF, 1'b1, 1'b0};
        tbl[5] = '{128'hA5_02_00000001_00000002_03, 11, 2, 6'd1,
                   32'h00000002, 1'b1, 1'b0};
        tbl[6] = '{128'h55_66, 2, 0, 6'd0, 32'h0, 1'b1, 1'b0};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_we", 64'(bus.imem_we), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_err", 64'(load_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Write and release timing on a 1-word frame
        got.delete();
        send(8'hA5);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        @(negedge clk);
        chk("t_we", 64'(bus.imem_we), 64'd1);
        chk("t_addr", 64'(bus.imem_addr), 64'd0);
        chk("t_wdata", 64'(bus.imem_wdata), 64'h12345678);
        chk("t_cpu_rst_hold", 64'(cpu_rst), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h08;
        @(negedge clk);
        chk("t_we_pulse", 64'(bus.imem_we), 64'd0);
        chk("t_cpu_rst_fall", 64'(cpu_rst), 64'd0);
        chk("t_done", 64'(load_done), 64'd1);
        idle(3);
        chk("t_nwr", 64'(got.size()), 64'd1);

        // Vector table, gap-free then with random gaps
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < 7; t++) begin
                got.delete();
                for (int i = 0; i < tbl[t].len; i++) begin
                    send_g(tbl[t].v[8*(tbl[t].len-1-i) +: 8], p * 3);
                end
                idle(3);
                chk($sformatf("v%0d_nwr", t), 64'(got.size()),
                    64'(tbl[t].nw));
                if (tbl[t].nw > 0 && got.size() > 0) begin
                    chk($sformatf("v%0d_last", t), 64'(got[$]),
                        64'({tbl[t].la, tbl[t].ld}));
                end
                chk($sformatf("v%0d_done", t), 64'(load_done),
                    64'(tbl[t].done));
                chk($sformatf("v%0d_err", t), 64'(load_err),
                    64'(tbl[t].err));
                chk($sformatf("v%0d_cpu_rst", t), 64'(cpu_rst),
                    64'(!tbl[t].done));
            end
        end

        // Full 64-word frame
        got.delete();
        s = {};
        x = 8'd0;
        s.push_back(SYNC_BYTE);
        s.push_back(8'd64);
        for (int k = 0; k < 64; k++) begin
            wd = 32'h1000_0000 + 32'(k);
            for (int j = 3; j >= 0; j--) begin
                s.push_back(wd[8*j +: 8]);
                x = x ^ wd[8*j +: 8];
            end
        end
        s.push_back(x);
        send_stream(s, 0);
        chk("f64_nwr", 64'(got.size()), 64'd64);
        for (int k = 0; k < 64 && k < got.size(); k++) begin
            chk("f64_wr", 64'(got[k]),
                64'({6'(k), 32'h1000_0000 + 32'(k)}));
        end
        chk("f64_done", 64'(load_done), 64'd1);
        chk("f64_cpu_rst", 64'(cpu_rst), 64'd0);

        // Reset after two payload bytes
        got.delete();
        send(8'hA5);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd0);
        chk("mr_we", 64'(bus.imem_we), 64'd0);
        chk("mr_addr", 64'(bus.imem_addr), 64'd0);
        chk("mr_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("mr_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("mr_done", 64'(load_done), 64'd0);
        chk("mr_err", 64'(load_err), 64'd0);
        rst = 1'b0;
        idle(2);
        chk("mr_nowrite", 64'(got.size()), 64'd0);
        s = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
        send_stream(s, 0);
        chk("mr_nwr", 64'(got.size()), 64'd1);
        if (got.size() > 0) begin
            chk("mr_wr", 64'(got[0]), 64'({6'd0, 32'hCAFEBABE}));
        end
        chk("mr_ok", 64'(load_done), 64'd1);

        // Random frames against the reference model
        for (int it = 0; it < 24; it++) begin
            do_reset();
            got.delete();
            s = {};
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == SYNC_BYTE) b = 8'h00;
                s.push_back(b);
            end
            repeat ($urandom_range(1, 2)) begin
                s.push_back(SYNC_BYTE);
                sel = int'($urandom_range(0, 7));
                if (sel == 0) c = 8'($urandom_range(65, 255));
                else if (sel == 1) c = 8'd0;
                else c = 8'($urandom_range(1, 12));
                s.push_back(c);
                if (count_ok(c)) begin
                    x = 8'd0;
                    for (int k = 0; k < 4 * int'(c); k++) begin
                        b = 8'($urandom);
                        s.push_back(b);
                        x = x ^ b;
                    end
                    if ($urandom_range(0, 3) == 0)
                        x = x ^ 8'($urandom_range(1, 255));
                    s.push_back(x);
                end else begin
                    s.push_back(8'h3C);
                    s.push_back(8'h11);
                end
            end
            send_stream(s, 2);
            compare_model($sformatf("rnd%0d", it), s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
